// File: rtl/tm1640_rx.sv
// Passive TM1640 bus receiver. It samples tm_clk/tm_din, rebuilds the bytes
// the transmitter sends and decodes them into display RAM, brightness and the
// on/off flag. The bus is only observed; nothing is ever driven onto it.
module tm1640_rx #(
    parameter int NUM_DIGITS  = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tm_clk,
    input  logic                    tm_din,
    output logic [8*NUM_DIGITS-1:0] data_pack,
    output logic [2:0]              level,
    output logic                    disp_on,
    output logic [7:0]              rx_byte,
    output logic                    byte_valid,
    output logic                    frame_done,
    output logic                    err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT_STOP
    } state_t;

    // Digit index range as a 5-bit value so that 16 digits still compares cleanly.
    localparam logic [4:0] NUM_DIGITS_L = 5'(NUM_DIGITS);

    // Synchronizer chains plus one extra stage for edge detection.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   clk_prev_q;
    logic                   din_prev_q;
    logic                   clk_cur;
    logic                   din_cur;

    // Frame state.
    state_t      state_q,      state_d;
    logic [7:0]  sr_q,         sr_d;
    logic [2:0]  bitcnt_q,     bitcnt_d;
    logic        byte_pend_q,  byte_pend_d;
    logic        fixed_addr_q, fixed_addr_d;
    logic [3:0]  addr_q,       addr_d;

    // Registered outputs.
    logic [7:0]  rx_byte_q,    rx_byte_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q,        err_d;
    logic [2:0]  level_q,      level_d;
    logic        disp_on_q,    disp_on_d;

    // Decoded bus events.
    logic        start_cond;
    logic        stop_cond;
    logic        bit_rise;
    logic        digit_we;

    assign clk_cur = clk_sync_q[SYNC_STAGES-1];
    assign din_cur = din_sync_q[SYNC_STAGES-1];

    // Start/stop are data transitions while the bus clock is high on both samples;
    // a bit is a bus clock rise, which by construction cannot coincide with either.
    assign start_cond = clk_prev_q & clk_cur &  din_prev_q & ~din_cur;
    assign stop_cond  = clk_prev_q & clk_cur & ~din_prev_q &  din_cur;
    assign bit_rise   = ~clk_prev_q & clk_cur & (state_q != ST_IDLE);

    // Bring the asynchronous bus pins into the clk domain; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            din_sync_q <= '1;
            clk_prev_q <= 1'b1;
            din_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], tm_din};
            clk_prev_q <= clk_cur;
            din_prev_q <= din_cur;
        end
    end

    // Frame/decode state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            bitcnt_q     <= '0;
            byte_pend_q  <= 1'b0;
            fixed_addr_q <= 1'b0;
            addr_q       <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            level_q      <= '0;
            disp_on_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bitcnt_q     <= bitcnt_d;
            byte_pend_q  <= byte_pend_d;
            fixed_addr_q <= fixed_addr_d;
            addr_q       <= addr_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            level_q      <= level_d;
            disp_on_q    <= disp_on_d;
        end
    end

    // Next-state logic: finish a pending byte first, then shift bits, then let
    // start/stop override the frame state.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bitcnt_d     = bitcnt_q;
        byte_pend_d  = 1'b0;
        fixed_addr_d = fixed_addr_q;
        addr_d       = addr_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        level_d      = level_q;
        disp_on_d    = disp_on_q;
        digit_we     = 1'b0;

        if (byte_pend_q) begin
            rx_byte_d    = sr_q;
            byte_valid_d = 1'b1;
            case (state_q)
                ST_CMD: begin
                    state_d = ST_WAIT_STOP;
                    case (sr_q[7:6])
                        2'b01: fixed_addr_d = sr_q[2];
                        2'b11: begin
                            addr_d  = sr_q[3:0];
                            state_d = ST_DATA;
                        end
                        2'b10: begin
                            disp_on_d = sr_q[3];
                            level_d   = sr_q[2:0];
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                ST_DATA: begin
                    // Addresses beyond the exposed digits are consumed but not stored.
                    digit_we = ({1'b0, addr_q} < NUM_DIGITS_L);
                    if (!fixed_addr_q) begin
                        addr_d = addr_q + 4'd1;
                    end
                end
                ST_WAIT_STOP: err_d = 1'b1;
                default: ;
            endcase
        end

        if (bit_rise) begin
            sr_d = {din_cur, sr_q[7:1]};
            if (bitcnt_q == 3'd7) begin
                bitcnt_d    = 3'd0;
                byte_pend_d = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end

        if (start_cond) begin
            if (state_q != ST_IDLE && bitcnt_q != 3'd0) begin
                err_d = 1'b1;
            end
            state_d  = ST_CMD;
            bitcnt_d = 3'd0;
        end else if (stop_cond && state_q != ST_IDLE) begin
            frame_done_d = 1'b1;
            if (bitcnt_q != 3'd0) begin
                err_d = 1'b1;
            end
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
        end
    end

    // One register per digit, written when its address receives a data byte.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [7:0] digit_q;

            // Capture the completed byte into this digit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    digit_q <= '0;
                end else if (digit_we && addr_q == 4'(gi)) begin
                    digit_q <= sr_q;
                end
            end

            assign data_pack[8*gi +: 8] = digit_q;
        end
    endgenerate

    assign level      = level_q;
    assign disp_on    = disp_on_q;
    assign rx_byte    = rx_byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_tm1640_rx.sv
// Directed bench for tm1640_rx: drives TM1640 frames on tm_clk/tm_din and
// checks the decoded outputs and pulse counts against hand-computed values.
module tb_tm1640_rx;

    localparam int NUM_DIGITS  = 9;
    localparam int SYNC_STAGES = 2;
    localparam int HB          = 6;   // clk cycles per bus phase

    logic                    clk;
    logic                    rst;
    logic                    tm_clk;
    logic                    tm_din;
    logic [8*NUM_DIGITS-1:0] data_pack;
    logic [2:0]              level;
    logic                    disp_on;
    logic [7:0]              rx_byte;
    logic                    byte_valid;
    logic                    frame_done;
    logic                    err;

    int n_vec = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int fd_cnt = 0;
    int er_cnt = 0;
    int bv0, fd0, er0;
    int lat;
    logic [71:0] lb_pat;

    tm1640_rx #(
        .NUM_DIGITS (NUM_DIGITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tm_clk    (tm_clk),
        .tm_din    (tm_din),
        .data_pack (data_pack),
        .level     (level),
        .disp_on   (disp_on),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (byte_valid) bv_cnt <= bv_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (err)        er_cnt <= er_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic snap();
        tick(1);
        bv0 = bv_cnt;
        fd0 = fd_cnt;
        er0 = er_cnt;
    endtask

    // Bus idle is clk=1/din=1; start pulls din low with clk high.
    task automatic bus_start();
        tm_din = 1'b0;
        tick(HB);
    endtask

    // Each bit: clk low, present data, clk high (sampled). Leaves clk high.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tm_clk = 1'b0;
            tick(HB);
            tm_din = b[i];
            tick(HB);
            tm_clk = 1'b1;
            tick(HB);
        end
    endtask

    // With clk high, din must end low before rising; if it is high, the
    // falling step is itself a repeated start at a byte boundary (harmless).
    task automatic bus_stop();
        if (tm_din) begin
            tm_din = 1'b0;
            tick(HB);
        end
        tm_din = 1'b1;
        tick(HB + 8);
    endtask

    // Repeated start from mid-byte: raising clk again clocks in one more bit.
    task automatic bus_restart();
        tm_clk = 1'b0;
        tick(HB);
        tm_din = 1'b1;
        tick(HB);
        tm_clk = 1'b1;
        tick(HB);
        tm_din = 1'b0;
        tick(HB);
    endtask

    task automatic frame1(input logic [7:0] b);
        bus_start();
        send_bits(b, 8);
        bus_stop();
    endtask

    initial begin
        rst    = 1'b1;
        tm_clk = 1'b1;
        tm_din = 1'b1;
        tick(5);

        // Reset state.
        chk("rst_data_pack",  data_pack,         72'h0);
        chk("rst_level",      72'(level),        72'h0);
        chk("rst_disp_on",    72'(disp_on),      72'h0);
        chk("rst_rx_byte",    72'(rx_byte),      72'h0);
        chk("rst_byte_valid", 72'(byte_valid),   72'h0);
        chk("rst_frame_done", 72'(frame_done),   72'h0);
        chk("rst_err",        72'(err),          72'h0);
        $display("reset checked");
        rst = 1'b0;
        tick(2);

        // Single data command 0x42 with latency measurement on its 8th bit.
        snap();
        bus_start();
        send_bits(8'h42, 7);
        tm_clk = 1'b0;
        tick(HB);
        tm_din = 1'b0;
        tick(HB);
        tm_clk = 1'b1;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (byte_valid && lat == 99) lat = k;
        end
        chk("latency", 72'(lat), 72'(SYNC_STAGES + 2));
        bus_stop();
        chk("f42_rx_byte", 72'(rx_byte),       72'h42);
        chk("f42_bv",      72'(bv_cnt - bv0),  72'd1);
        chk("f42_fd",      72'(fd_cnt - fd0),  72'd1);
        chk("f42_err",     72'(er_cnt - er0),  72'd0);
        $display("frame 0x42: rx_byte=%h latency=%0d", rx_byte, lat);

        // Address 0 then nine incrementing data bytes.
        snap();
        bus_start();
        send_bits(8'hC0, 8);
        for (int i = 1; i <= 9; i++) send_bits(8'(i), 8);
        bus_stop();
        chk("burst_data", data_pack, 72'h090807060504030201);
        chk("burst_bv",   72'(bv_cnt - bv0), 72'd10);
        chk("burst_err",  72'(er_cnt - er0), 72'd0);
        $display("frame burst: data_pack=%h", data_pack);

        // Display control on/off.
        frame1(8'h8B);
        chk("ctl8b_disp_on", 72'(disp_on), 72'd1);
        chk("ctl8b_level",   72'(level),   72'd3);
        $display("frame 0x8B: disp_on=%0d level=%0d", disp_on, level);
        frame1(8'h80);
        chk("ctl80_disp_on", 72'(disp_on), 72'd0);
        chk("ctl80_level",   72'(level),   72'd0);
        $display("frame 0x80: disp_on=%0d level=%0d", disp_on, level);

        // Fixed address mode: both bytes land on digit 3.
        frame1(8'h44);
        bus_start();
        send_bits(8'hC3, 8);
        send_bits(8'hAA, 8);
        send_bits(8'h55, 8);
        bus_stop();
        chk("fixed_data", data_pack, 72'h090807060555030201);
        $display("frame fixed: data_pack=%h", data_pack);

        // Auto increment from 15: first byte dropped, address wraps to 0.
        snap();
        frame1(8'h40);
        bus_start();
        send_bits(8'hCF, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        bus_stop();
        chk("wrap_data", data_pack, 72'h090807060555030222);
        chk("wrap_err",  72'(er_cnt - er0), 72'd0);
        $display("frame wrap: data_pack=%h", data_pack);

        // Stop after 5 bits: partial byte discarded with err.
        snap();
        bus_start();
        send_bits(8'h00, 5);
        bus_stop();
        chk("part_err", 72'(er_cnt - er0), 72'd1);
        chk("part_fd",  72'(fd_cnt - fd0), 72'd1);
        chk("part_bv",  72'(bv_cnt - bv0), 72'd0);
        $display("frame partial: err pulses=%0d", er_cnt - er0);

        // Invalid command 0x00.
        snap();
        frame1(8'h00);
        chk("bad_err", 72'(er_cnt - er0), 72'd1);
        chk("bad_bv",  72'(bv_cnt - bv0), 72'd1);
        chk("bad_rx",  72'(rx_byte),      72'h00);
        $display("frame 0x00: err pulses=%0d", er_cnt - er0);

        // Extra byte after display control: reported, not decoded, err.
        snap();
        bus_start();
        send_bits(8'h8A, 8);
        send_bits(8'h8F, 8);
        bus_stop();
        chk("ws_rx",      72'(rx_byte),      72'h8F);
        chk("ws_level",   72'(level),        72'd2);
        chk("ws_disp_on", 72'(disp_on),      72'd1);
        chk("ws_err",     72'(er_cnt - er0), 72'd1);
        chk("ws_bv",      72'(bv_cnt - bv0), 72'd2);
        $display("frame wait_stop: rx_byte=%h level=%0d", rx_byte, level);

        // Restart mid-byte, then a clean address/data sequence.
        snap();
        bus_start();
        send_bits(8'hC0, 3);
        bus_restart();
        send_bits(8'hC8, 8);
        send_bits(8'h77, 8);
        bus_stop();
        chk("rs_err",  72'(er_cnt - er0), 72'd1);
        chk("rs_bv",   72'(bv_cnt - bv0), 72'd2);
        chk("rs_data", data_pack, 72'h770807060555030222);
        $display("frame restart: data_pack=%h", data_pack);

        // Loopback-style full display load plus brightness.
        lb_pat = 72'h0123456789ABCDEF01;
        frame1(8'h40);
        bus_start();
        send_bits(8'hC0, 8);
        for (int i = 0; i < 9; i++) send_bits(lb_pat[8*i +: 8], 8);
        bus_stop();
        frame1(8'h8B);
        chk("lb_data",    data_pack,    72'h0123456789ABCDEF01);
        chk("lb_level",   72'(level),   72'd3);
        chk("lb_disp_on", 72'(disp_on), 72'd1);
        $display("frame loopback: data_pack=%h level=%0d", data_pack, level);

        // Reset mid-byte clears every output.
        bus_start();
        send_bits(8'hC0, 4);
        rst = 1'b1;
        tick(2);
        chk("mrst_data",    data_pack,         72'h0);
        chk("mrst_level",   72'(level),        72'h0);
        chk("mrst_disp_on", 72'(disp_on),      72'h0);
        chk("mrst_rx_byte", 72'(rx_byte),      72'h0);
        chk("mrst_pulses",  72'({byte_valid, frame_done, err}), 72'h0);
        tm_clk = 1'b0;
        tick(HB);
        tm_din = 1'b1;
        tick(HB);
        tm_clk = 1'b1;
        tick(HB);
        rst = 1'b0;
        tick(HB);
        $display("mid-byte reset checked");

        // Receiver works again after reset.
        snap();
        frame1(8'h8B);
        chk("post_level", 72'(level),        72'd3);
        chk("post_err",   72'(er_cnt - er0), 72'd0);
        chk("post_data",  data_pack,         72'h0);
        $display("frame post-reset: level=%0d", level);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
